deal_ctrl: RTL and testbench
============================

// Module: deal_ctrl
// PURPOSE
// Blackjack round sequencer. Pulls cards from a random card source over a req/ack
// handshake and assigns each one to a player or dealer hand slot. It tracks hand values,
// including soft aces, and runs the player and dealer turns to a round result.
// Slot writes feed the per-slot card drawing instances, which take card_symbol/card_number,
// in the VGA pipeline.
// PARAMETERS
// MAX_CARDS     5   card slots per hand (2..7); slot_idx is 3 bits
// DEALER_STAND  17  dealer stops drawing when hand value >= this
// PORTS
// clk           in   1  system clock
// rst           in   1  synchronous reset, active high
// new_game      in   1  1-cycle pulse: clear hands, start a deal
// hit           in   1  1-cycle pulse: player requests a card
// stand         in   1  1-cycle pulse: player ends turn
// draw_req      out  1  request to card source
// draw_ack      in   1  card source has valid card this cycle
// src_symbol    in   2  suit from source
// src_number    in   4  rank from source: 1=A, 2..10, 11..13=J/Q/K
// slot_we       out  1  1-cycle strobe: write slot
// slot_owner    out  1  0=player, 1=dealer
// slot_idx      out  3  slot index 0..MAX_CARDS-1
// card_symbol   out  2  suit for the written slot
// card_number   out  4  rank for the written slot
// player_value  out  5  best player hand value, saturates at 31
// dealer_value  out  5  best dealer hand value, saturates at 31
// player_turn   out  1  high in PLAYER_TURN only
// result        out  2  0=none, 1=player win, 2=dealer win, 3=push
// BEHAVIOUR
// - Reset: all outputs 0, hands and counters cleared, state IDLE. Reset overrides every input.
// - States: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_TURN, PLAYER_DRAW,
//   DEALER_TURN, DEALER_DRAW, DONE.
// - new_game in any state: next cycle clears counts, values and result, then enters DEAL_P1.
//   An outstanding draw_req drops and a pending card is discarded.
// - Draw states (DEAL_*, *_DRAW) hold draw_req=1 until draw_ack.
//   - On ack with src_number in 1..13, the card is captured. Next cycle: slot_we=1 with the
//     slot fields, hand count +1, value updated, draw_req=0, state advances.
//   - On ack with src_number 0 or 14..15, the card is ignored and draw_req stays high.
// - Deal order: P1 -> D1 -> P2 -> D2 -> PLAYER_TURN. Slot idx = the hand's count before the write.
// - Card worth: A=1 (hard); 11..13 = 10; else the rank.
//   Per hand: hard_sum (6 bit) and ace_seen.
//   value = hard_sum+10 if ace_seen and hard_sum<=11, else hard_sum; saturate to 31.
// - After DEAL_D2: if player_value==21, go to DEALER_TURN; otherwise go to PLAYER_TURN.
// - PLAYER_TURN:
//   - stand -> DEALER_TURN.
//   - hit -> PLAYER_DRAW.
//   - hit and stand in the same cycle: stand wins.
//   - hit/stand outside PLAYER_TURN are ignored.
// - After PLAYER_DRAW:
//   - value>21 -> DONE with result=2; the dealer does not draw.
//   - count==MAX_CARDS -> DEALER_TURN (auto stand).
//   - otherwise -> PLAYER_TURN.
// - DEALER_TURN:
//   - dealer_value<DEALER_STAND and count<MAX_CARDS -> DEALER_DRAW, then back to DEALER_TURN.
//   - otherwise -> DONE.
// - DONE result (set on entry, held until new_game/rst):
//   - dealer>21 or player>dealer -> 1.
//   - player<dealer -> 2.
//   - equal -> 3.
// - Latency: ack at cycle N -> slot_we and updated value at N+1 -> next draw_req earliest at N+2.
// - At most one slot_we per 2 cycles. slot_* hold their last values when slot_we=0.
// TESTING
// - rst mid-DEAL_D1 with draw_req=1 -> next cycle draw_req=0, state IDLE, values 0, result 0.
// - new_game; source returns 10,7,A,9 -> four slot_we: P0/D0/P1/D1;
//   player_value=21, dealer_value=16; goes straight to the dealer turn;
//   dealer draws 5 -> 21 -> result=3.
// - Deal 10,9,6,7; hit gives K -> player 26, result=2, no dealer draw_req after the bust.
// - Ack with src_number=0 then 14 -> no slot_we, draw_req stays 1;
//   then 5 -> accepted at slot 0.
// - Soft ace: player A,6 -> 17; hit 9 -> 16 (hard); hit+stand same cycle -> stand taken, no draw.
// - MAX_CARDS=5: player hits 2,2,2 after deal 2,2 -> 10 with 5 cards -> auto DEALER_TURN;
//   extra hit pulses ignored.

Source files
------------

// File: rtl/deal_ctrl.sv
// Blackjack round sequencer: pulls cards over a req/ack handshake, writes hand slots,
// tracks soft-ace hand values and runs player/dealer turns to a round result.
module deal_ctrl #(
   parameter int MAX_CARDS    = 5,
   parameter int DEALER_STAND = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_game,
   input  logic       hit,
   input  logic       stand,
   output logic       draw_req,
   input  logic       draw_ack,
   input  logic [1:0] src_symbol,
   input  logic [3:0] src_number,
   output logic       slot_we,
   output logic       slot_owner,
   output logic [2:0] slot_idx,
   output logic [1:0] card_symbol,
   output logic [3:0] card_number,
   output logic [4:0] player_value,
   output logic [4:0] dealer_value,
   output logic       player_turn,
   output logic [1:0] result
);

   typedef enum logic [3:0] {
      IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
      PLAYER_TURN, PLAYER_DRAW, DEALER_TURN, DEALER_DRAW, DONE
   } state_t;

   localparam logic [3:0] MAX_V   = 4'(MAX_CARDS);
   localparam logic [4:0] STAND_V = 5'(DEALER_STAND);

   state_t     state, state_nx;
   logic [1:0] result_nx;
   logic [5:0] p_hard, d_hard, p_hard_add, d_hard_add, worth;
   logic       p_ace, d_ace, p_ace_add, d_ace_add;
   logic [2:0] p_cnt, d_cnt;
   logic [4:0] p_val_add;
   logic       card_ok, take, to_dealer;

   function automatic logic [5:0] card_worth(input logic [3:0] num);
      return (num >= 4'd10) ? 6'd10 : {2'b00, num};
   endfunction

   // An ace counts 11 only while that keeps the hard total at or below 21.
   function automatic logic [4:0] hand_value(input logic [5:0] hard, input logic ace);
      logic [5:0] v;
      v = (ace && hard <= 6'd11) ? hard + 6'd10 : hard;
      return (v > 6'd31) ? 5'd31 : v[4:0];
   endfunction

   function automatic logic is_draw(input state_t s);
      return s inside {DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_DRAW, DEALER_DRAW};
   endfunction

   assign player_value = hand_value(p_hard, p_ace);
   assign dealer_value = hand_value(d_hard, d_ace);
   assign player_turn  = (state == PLAYER_TURN);

   always_comb begin
      card_ok    = (src_number >= 4'd1) && (src_number <= 4'd13);
      take       = draw_req && draw_ack && card_ok && is_draw(state);
      to_dealer  = state inside {DEAL_D1, DEAL_D2, DEALER_DRAW};
      worth      = card_worth(src_number);
      p_hard_add = p_hard + worth;
      d_hard_add = d_hard + worth;
      p_ace_add  = p_ace || (src_number == 4'd1);
      d_ace_add  = d_ace || (src_number == 4'd1);
      p_val_add  = hand_value(p_hard_add, p_ace_add);
      state_nx   = state;
      result_nx  = result;
      case (state)
         DEAL_P1:     if (take) state_nx = DEAL_D1;
         DEAL_D1:     if (take) state_nx = DEAL_P2;
         DEAL_P2:     if (take) state_nx = DEAL_D2;
         DEAL_D2:     if (take) state_nx = (player_value == 5'd21) ? DEALER_TURN : PLAYER_TURN;
         PLAYER_TURN: begin
            if (stand)    state_nx = DEALER_TURN;
            else if (hit) state_nx = PLAYER_DRAW;
         end
         PLAYER_DRAW: begin
            if (take) begin
               if (p_val_add > 5'd21) begin
                  state_nx  = DONE;
                  result_nx = 2'd2;
               end else if ({1'b0, p_cnt} + 4'd1 == MAX_V) begin
                  state_nx = DEALER_TURN;
               end else begin
                  state_nx = PLAYER_TURN;
               end
            end
         end
         DEALER_TURN: begin
            if (dealer_value < STAND_V && {1'b0, d_cnt} < MAX_V) begin
               state_nx = DEALER_DRAW;
            end else begin
               state_nx = DONE;
               if (dealer_value > 5'd21 || player_value > dealer_value) result_nx = 2'd1;
               else if (player_value < dealer_value)                    result_nx = 2'd2;
               else                                                     result_nx = 2'd3;
            end
         end
         DEALER_DRAW: if (take) state_nx = DEALER_TURN;
         default: ;
      endcase
      if (new_game) begin
         state_nx  = DEAL_P1;
         result_nx = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         result      <= 2'd0;
         draw_req    <= 1'b0;
         slot_we     <= 1'b0;
         slot_owner  <= 1'b0;
         slot_idx    <= 3'd0;
         card_symbol <= 2'd0;
         card_number <= 4'd0;
         p_hard      <= 6'd0;
         d_hard      <= 6'd0;
         p_ace       <= 1'b0;
         d_ace       <= 1'b0;
         p_cnt       <= 3'd0;
         d_cnt       <= 3'd0;
      end else begin
         state    <= state_nx;
         result   <= result_nx;
         slot_we  <= 1'b0;
         // Request drops for the write cycle, giving at most one slot write per two cycles.
         draw_req <= is_draw(state_nx) && !take && !new_game;
         if (new_game) begin
            p_hard <= 6'd0;
            d_hard <= 6'd0;
            p_ace  <= 1'b0;
            d_ace  <= 1'b0;
            p_cnt  <= 3'd0;
            d_cnt  <= 3'd0;
         end else if (take) begin
            slot_we     <= 1'b1;
            slot_owner  <= to_dealer;
            slot_idx    <= to_dealer ? d_cnt : p_cnt;
            card_symbol <= src_symbol;
            card_number <= src_number;
            if (to_dealer) begin
               d_hard <= d_hard_add;
               d_ace  <= d_ace_add;
               d_cnt  <= d_cnt + 3'd1;
            end else begin
               p_hard <= p_hard_add;
               p_ace  <= p_ace_add;
               p_cnt  <= p_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_deal_ctrl.sv
// Bench for deal_ctrl: a cycle-exact vector table, directed rounds and random rounds
// scored against a card-list model of blackjack hands.
module tb_deal_ctrl;

   localparam int MAXC = 5;

   logic       clk = 1'b0;
   logic       rst, new_game, hit, stand, draw_ack;
   logic [1:0] src_symbol;
   logic [3:0] src_number;
   logic       draw_req, slot_we, slot_owner, player_turn;
   logic [2:0] slot_idx;
   logic [1:0] card_symbol, result;
   logic [3:0] card_number;
   logic [4:0] player_value, dealer_value;

   int checks = 0;
   int failures = 0;
   int deck[$];
   int pq[$];
   int dq[$];

   typedef struct {
      int ng, ht, st, num;
      int we, dreq, pv, dv, res, pt, own, idx;
   } vec_t;
   vec_t vt[$];

   deal_ctrl #(.MAX_CARDS(MAXC), .DEALER_STAND(17)) dut (
      .clk(clk), .rst(rst), .new_game(new_game), .hit(hit), .stand(stand),
      .draw_req(draw_req), .draw_ack(draw_ack), .src_symbol(src_symbol),
      .src_number(src_number), .slot_we(slot_we), .slot_owner(slot_owner),
      .slot_idx(slot_idx), .card_symbol(card_symbol), .card_number(card_number),
      .player_value(player_value), .dealer_value(dealer_value),
      .player_turn(player_turn), .result(result)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Best blackjack total of a list of ranks, capped at 31.
   function automatic int hand_val(input int q[$]);
      int s;
      bit a;
      s = 0;
      a = 0;
      foreach (q[i]) begin
         s += (q[i] > 10) ? 10 : q[i];
         if (q[i] == 1) a = 1;
      end
      if (a && s <= 11) s += 10;
      return (s > 31) ? 31 : s;
   endfunction

   function automatic int next_card();
      if (deck.size() > 0) return deck.pop_front();
      return $urandom_range(1, 13);
   endfunction

   function automatic vec_t mk(int ng, int ht, int st, int num, int we, int dreq,
                               int pv, int dv, int res, int pt, int own, int idx);
      vec_t v;
      v.ng = ng; v.ht = ht; v.st = st; v.num = num; v.we = we; v.dreq = dreq;
      v.pv = pv; v.dv = dv; v.res = res; v.pt = pt; v.own = own; v.idx = idx;
      return v;
   endfunction

   task automatic pulse(input bit h, input bit s, input bit n);
      hit = h; stand = s; new_game = n;
      tick();
      hit = 0; stand = 0; new_game = 0;
   endtask

   task automatic give_card(input bit own, input int bad);
      int num, sym, idx, w;
      num = next_card();
      sym = $urandom_range(0, 3);
      w = 0;
      while (draw_req !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      chk("dreq_wait", draw_req, 1);
      repeat ($urandom_range(0, 2)) begin
         tick();
         chk("dreq_hold", draw_req, 1);
      end
      for (int b = 0; b < bad; b++) begin
         draw_ack = 1;
         src_number = (b % 2 == 0) ? 4'd0 : 4'($urandom_range(14, 15));
         src_symbol = 2'($urandom_range(0, 3));
         tick();
         draw_ack = 0;
         chk("bad_we", slot_we, 0);
         chk("bad_dreq", draw_req, 1);
      end
      draw_ack = 1;
      src_number = 4'(num);
      src_symbol = 2'(sym);
      tick();
      draw_ack = 0;
      src_number = 0;
      if (own) begin
         idx = dq.size();
         dq.push_back(num);
      end else begin
         idx = pq.size();
         pq.push_back(num);
      end
      chk("we", slot_we, 1);
      chk("owner", slot_owner, own);
      chk("idx", slot_idx, idx);
      chk("number", card_number, num);
      chk("symbol", card_symbol, sym);
      chk("pval", player_value, hand_val(pq));
      chk("dval", dealer_value, hand_val(dq));
      chk("dreq_drop", draw_req, 0);
   endtask

   task automatic run_round(input int thresh, input int max_hits, input bit both,
                            input int extra, input int bad);
      int hits, pv, dv, er;
      pulse(0, 0, 1);
      chk("ng_pval", player_value, 0);
      chk("ng_dval", dealer_value, 0);
      chk("ng_res", result, 0);
      chk("ng_dreq", draw_req, 0);
      pq.delete();
      dq.delete();
      give_card(0, bad);
      give_card(1, 0);
      give_card(0, 0);
      give_card(1, 0);
      chk("pturn_deal", player_turn, hand_val(pq) != 21);
      if (hand_val(pq) != 21) begin
         hits = 0;
         while (hand_val(pq) < thresh && hits < max_hits && pq.size() < MAXC) begin
            pulse(1, 0, 0);
            give_card(0, 0);
            hits++;
            if (hand_val(pq) > 21) break;
            chk("pturn_hit", player_turn, pq.size() < MAXC);
         end
         if (hand_val(pq) > 21) begin
            repeat (8) begin
               tick();
               chk("bust_dreq", draw_req, 0);
            end
            chk("bust_res", result, 2);
            return;
         end
         if (pq.size() < MAXC) pulse(both, 1, 0);
         for (int e = 0; e < extra; e++) pulse(1, 0, 0);
      end
      while (hand_val(dq) < 17 && dq.size() < MAXC) give_card(1, 0);
      repeat (6) begin
         tick();
         chk("end_dreq", draw_req, 0);
      end
      pv = hand_val(pq);
      dv = hand_val(dq);
      er = (dv > 21 || pv > dv) ? 1 : (pv < dv) ? 2 : 3;
      chk("result", result, er);
      chk("pturn_end", player_turn, 0);
   endtask

   initial begin
      rst = 1; new_game = 0; hit = 0; stand = 0; draw_ack = 0;
      src_symbol = 0; src_number = 0;
      repeat (2) tick();
      chk("rst_dreq", draw_req, 0);
      chk("rst_we", slot_we, 0);
      chk("rst_pval", player_value, 0);
      chk("rst_dval", dealer_value, 0);
      chk("rst_res", result, 0);
      chk("rst_pturn", player_turn, 0);
      rst = 0;
      tick();

      // Deal 10,7,A,9: player 21 goes straight to dealer, dealer draws 5 for a push.
      vt.push_back(mk(1,0,0, 0, 0,0, 0, 0,0,0, 0,0));
      vt.push_back(mk(0,0,0, 0, 0,1, 0, 0,0,0, 0,0));
      vt.push_back(mk(0,0,0,10, 1,0,10, 0,0,0, 0,0));
      vt.push_back(mk(0,0,0, 0, 0,1,10, 0,0,0, 0,0));
      vt.push_back(mk(0,0,0, 7, 1,0,10, 7,0,0, 1,0));
      vt.push_back(mk(0,0,0, 0, 0,1,10, 7,0,0, 0,0));
      vt.push_back(mk(0,0,0, 1, 1,0,21, 7,0,0, 0,1));
      vt.push_back(mk(0,0,0, 0, 0,1,21, 7,0,0, 0,0));
      vt.push_back(mk(0,0,0, 9, 1,0,21,16,0,0, 1,1));
      vt.push_back(mk(0,1,0, 0, 0,1,21,16,0,0, 0,0));
      vt.push_back(mk(0,0,0, 5, 1,0,21,21,0,0, 1,2));
      vt.push_back(mk(0,0,1, 0, 0,0,21,21,3,0, 0,0));
      vt.push_back(mk(0,0,0, 0, 0,0,21,21,3,0, 0,0));
      for (int i = 0; i < vt.size(); i++) begin
         new_game = vt[i].ng[0];
         hit = vt[i].ht[0];
         stand = vt[i].st[0];
         draw_ack = (vt[i].num != 0);
         src_number = 4'(vt[i].num);
         src_symbol = 2'(i % 4);
         tick();
         new_game = 0; hit = 0; stand = 0; draw_ack = 0; src_number = 0;
         chk("tv_we", slot_we, vt[i].we);
         chk("tv_dreq", draw_req, vt[i].dreq);
         chk("tv_pval", player_value, vt[i].pv);
         chk("tv_dval", dealer_value, vt[i].dv);
         chk("tv_res", result, vt[i].res);
         chk("tv_pturn", player_turn, vt[i].pt);
         if (vt[i].we != 0) begin
            chk("tv_owner", slot_owner, vt[i].own);
            chk("tv_idx", slot_idx, vt[i].idx);
            chk("tv_number", card_number, vt[i].num);
            chk("tv_symbol", card_symbol, i % 4);
         end
      end

      // Reset while the first dealer card is being requested.
      pulse(0, 0, 1);
      pq.delete();
      dq.delete();
      deck = '{8};
      give_card(0, 0);
      tick();
      chk("mid_pre_dreq", draw_req, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("mid_rst_dreq", draw_req, 0);
      chk("mid_rst_pval", player_value, 0);
      chk("mid_rst_dval", dealer_value, 0);
      chk("mid_rst_res", result, 0);
      chk("mid_rst_we", slot_we, 0);
      repeat (3) tick();
      chk("mid_rst_idle", draw_req, 0);

      // Player busts with K on 16; dealer must not draw.
      deck = '{10, 9, 6, 7, 13};
      run_round(21, 10, 0, 0, 0);
      // Ranks 0 and 14 ignored before a 5 lands in slot 0.
      deck = '{5, 10, 10, 8};
      run_round(0, 0, 0, 0, 2);
      // Soft 17 becomes hard 16 after a 9; then hit+stand together stands.
      deck = '{1, 10, 6, 8, 9};
      run_round(18, 1, 1, 0, 0);
      // Five-card auto stand at 10, stray hits ignored, dealer draws 3 to 19.
      deck = '{2, 10, 2, 6, 2, 2, 2, 3};
      run_round(21, 10, 0, 3, 0);

      deck.delete();
      for (int r = 0; r < 40; r++)
         run_round($urandom_range(12, 21), 7, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 1), $urandom_range(0, 2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
